// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline-register layouts for the execute stage.
package y86_pkg;

    localparam int XLEN = 64;
    localparam logic [3:0] RNONE_C = 4'hF;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVXX = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_XOR  = 4'h3,
        ALU_NONE = 4'hF
    } alu_fun_e;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_e;

    typedef struct packed {
        logic            valid;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [XLEN-1:0] valA;
        logic [XLEN-1:0] valB;
        logic [XLEN-1:0] valC;
        logic [XLEN-1:0] valP;
        logic [3:0]      dstE;
        logic [3:0]      dstM;
    } e_reg_t;

    typedef struct packed {
        logic            valid;
        logic [3:0]      icode;
        logic            cnd;
        logic [XLEN-1:0] valE;
        logic [XLEN-1:0] valA;
        logic [XLEN-1:0] valP;
        logic [3:0]      dstE;
        logic [3:0]      dstM;
    } m_reg_t;

    // cc is {ZF,SF,OF}
    function automatic logic cond_eval(input logic [2:0] cc_v, input logic [3:0] fn);
        logic zf;
        logic sf;
        logic of;
        logic res;
        {zf, sf, of} = cc_v;
        case (fn)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: computes aluB op aluA and the {ZF,SF,OF} flags.
module y86_alu
    import y86_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] i_alu_a,
    input  logic [W-1:0] i_alu_b,
    input  logic [3:0]   i_alu_fun,
    output logic [W-1:0] o_result,
    output logic [2:0]   o_flags
);

    logic [W-1:0] w_res;
    logic         w_of;

    // Operation select; unknown function codes yield zero with no overflow
    always_comb begin
        w_res = {W{1'b0}};
        w_of  = 1'b0;
        case (i_alu_fun)
            ALU_ADD: begin
                w_res = i_alu_b + i_alu_a;
                w_of  = (i_alu_a[W-1] == i_alu_b[W-1]) && (w_res[W-1] != i_alu_a[W-1]);
            end
            ALU_SUB: begin
                w_res = i_alu_b - i_alu_a;
                w_of  = (i_alu_a[W-1] != i_alu_b[W-1]) && (w_res[W-1] != i_alu_b[W-1]);
            end
            ALU_AND: w_res = i_alu_b & i_alu_a;
            ALU_XOR: w_res = i_alu_b ^ i_alu_a;
            default: w_res = {W{1'b0}};
        endcase
    end

    assign o_result = w_res;
    assign o_flags  = {(w_res == {W{1'b0}}), w_res[W-1], w_of};

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and M pipeline register,
// with combinational valE/dstE forwarding taps for decode.
module execute_stage
    import y86_pkg::*;
#(
    parameter int         W     = XLEN,
    parameter logic [3:0] RNONE = RNONE_C
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d_valid,
    input  logic [3:0]   d_icode,
    input  logic [3:0]   d_ifun,
    input  logic [W-1:0] d_valA,
    input  logic [W-1:0] d_valB,
    input  logic [W-1:0] d_valC,
    input  logic [W-1:0] d_valP,
    input  logic [3:0]   d_dstE,
    input  logic [3:0]   d_dstM,
    input  logic         stall,
    input  logic         e_bubble,
    input  logic         m_bubble,
    input  logic         cc_hold,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         m_valid,
    output logic [3:0]   m_icode,
    output logic         m_cnd,
    output logic [W-1:0] m_valE,
    output logic [W-1:0] m_valA,
    output logic [W-1:0] m_valP,
    output logic [3:0]   m_dstE,
    output logic [3:0]   m_dstM,
    output logic [2:0]   cc
);

    localparam e_reg_t E_NOP = '{valid: 1'b0, icode: I_NOP, ifun: 4'h0,
                                 valA: {XLEN{1'b0}}, valB: {XLEN{1'b0}},
                                 valC: {XLEN{1'b0}}, valP: {XLEN{1'b0}},
                                 dstE: RNONE, dstM: RNONE};
    localparam m_reg_t M_NOP = '{valid: 1'b0, icode: I_NOP, cnd: 1'b0,
                                 valE: {XLEN{1'b0}}, valA: {XLEN{1'b0}},
                                 valP: {XLEN{1'b0}}, dstE: RNONE, dstM: RNONE};
    localparam logic [W-1:0] STACK_STEP = {{(W-4){1'b0}}, 4'h8};

    e_reg_t       r_e;
    m_reg_t       r_m;
    logic [2:0]   r_cc;

    logic [W-1:0] w_alu_a;
    logic [W-1:0] w_alu_b;
    logic [3:0]   w_alu_fun;
    logic [W-1:0] w_alu_res;
    logic [2:0]   w_alu_flags;
    logic         w_cnd;
    logic [3:0]   w_dst_e;
    logic         w_cc_we;
    e_reg_t       w_e_load;
    m_reg_t       w_m_load;

    // ALU operand and function selection by instruction class
    always_comb begin
        w_alu_a   = r_e.valA;
        w_alu_b   = r_e.valB;
        w_alu_fun = ALU_NONE;
        case (r_e.icode)
            I_OPQ:            w_alu_fun = r_e.ifun;
            I_RMMOVQ, I_MRMOVQ: begin
                w_alu_a   = r_e.valC;
                w_alu_fun = ALU_ADD;
            end
            I_IRMOVQ: begin
                w_alu_a   = r_e.valC;
                w_alu_b   = {W{1'b0}};
                w_alu_fun = ALU_ADD;
            end
            I_CMOVXX: begin
                w_alu_b   = {W{1'b0}};
                w_alu_fun = ALU_ADD;
            end
            I_PUSHQ, I_CALL: begin
                w_alu_a   = STACK_STEP;
                w_alu_fun = ALU_SUB;
            end
            I_POPQ, I_RET: begin
                w_alu_a   = STACK_STEP;
                w_alu_fun = ALU_ADD;
            end
            default:          w_alu_fun = ALU_NONE;
        endcase
    end

    y86_alu #(.W(W)) u_alu (
        .i_alu_a   (w_alu_a),
        .i_alu_b   (w_alu_b),
        .i_alu_fun (w_alu_fun),
        .o_result  (w_alu_res),
        .o_flags   (w_alu_flags)
    );

    assign w_cnd   = ((r_e.icode == I_CMOVXX) || (r_e.icode == I_JXX)) ? cond_eval(r_cc, r_e.ifun) : 1'b0;
    assign w_dst_e = ((r_e.icode == I_CMOVXX) && !w_cnd) ? RNONE : r_e.dstE;
    // An OPq squashed by m_bubble never reaches M, so it must not touch CC either
    assign w_cc_we = !stall && !m_bubble && !cc_hold && r_e.valid &&
                     (r_e.icode == I_OPQ) && (r_e.ifun <= 4'h3);

    assign w_e_load = '{valid: d_valid, icode: d_icode, ifun: d_ifun,
                        valA: d_valA, valB: d_valB, valC: d_valC, valP: d_valP,
                        dstE: d_dstE, dstM: d_dstM};
    assign w_m_load = '{valid: r_e.valid, icode: r_e.icode, cnd: w_cnd,
                        valE: w_alu_res, valA: r_e.valA, valP: r_e.valP,
                        dstE: w_dst_e, dstM: r_e.dstM};

    // E pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e <= E_NOP;
        end else if (stall) begin
            r_e <= r_e;
        end else if (e_bubble) begin
            r_e <= E_NOP;
        end else begin
            r_e <= w_e_load;
        end
    end

    // M pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= M_NOP;
        end else if (stall) begin
            r_m <= r_m;
        end else if (m_bubble) begin
            r_m <= M_NOP;
        end else begin
            r_m <= w_m_load;
        end
    end

    // Condition-code register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= 3'b100;
        end else if (w_cc_we) begin
            r_cc <= w_alu_flags;
        end else begin
            r_cc <= r_cc;
        end
    end

    assign e_valE  = w_alu_res;
    assign e_dstE  = w_dst_e;
    assign m_valid = r_m.valid;
    assign m_icode = r_m.icode;
    assign m_cnd   = r_m.cnd;
    assign m_valE  = r_m.valE;
    assign m_valA  = r_m.valA;
    assign m_valP  = r_m.valP;
    assign m_dstE  = r_m.dstE;
    assign m_dstM  = r_m.dstM;
    assign cc      = r_cc;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural instruction-level model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid;
    logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB, d_valC, d_valP;
    logic        stall, e_bubble, m_bubble, cc_hold;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        m_valid, m_cnd;
    logic [3:0]  m_icode, m_dstE, m_dstM;
    logic [63:0] m_valE, m_valA, m_valP;
    logic [2:0]  cc;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic [3:0]  ic, fn;
        logic [63:0] a, b, c, p;
        logic [3:0]  de, dm;
    } einst_t;

    typedef struct {
        logic        v;
        logic [3:0]  ic;
        logic        cnd;
        logic [63:0] ve, a, p;
        logic [3:0]  de, dm;
    } minst_t;

    einst_t     me;
    minst_t     mm;
    logic [2:0] mcc;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC), .d_valP(d_valP),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .stall(stall), .e_bubble(e_bubble),
        .m_bubble(m_bubble), .cc_hold(cc_hold), .e_valE(e_valE), .e_dstE(e_dstE),
        .m_valid(m_valid), .m_icode(m_icode), .m_cnd(m_cnd), .m_valE(m_valE),
        .m_valA(m_valA), .m_valP(m_valP), .m_dstE(m_dstE), .m_dstM(m_dstM), .cc(cc)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_valE(einst_t e);
        case (e.ic)
            4'h6: begin
                case (e.fn)
                    4'h0:    return e.b + e.a;
                    4'h1:    return e.b - e.a;
                    4'h2:    return e.b & e.a;
                    4'h3:    return e.b ^ e.a;
                    default: return 64'd0;
                endcase
            end
            4'h4, 4'h5: return e.b + e.c;
            4'h3:       return e.c;
            4'h2:       return e.a;
            4'hA, 4'h8: return e.b - 64'd8;
            4'hB, 4'h9: return e.b + 64'd8;
            default:    return 64'd0;
        endcase
    endfunction

    // Overflow: the exact signed result does not fit in 64 bits
    function automatic logic [2:0] ref_flags(einst_t e);
        logic [63:0]        r;
        logic signed [64:0] s;
        logic               of;
        r  = ref_valE(e);
        of = 1'b0;
        if (e.fn == 4'h0) begin
            s  = $signed({e.a[63], e.a}) + $signed({e.b[63], e.b});
            of = (s[64] != s[63]);
        end else if (e.fn == 4'h1) begin
            s  = $signed({e.b[63], e.b}) - $signed({e.a[63], e.a});
            of = (s[64] != s[63]);
        end
        return {(r == 64'd0), r[63], of};
    endfunction

    function automatic logic ref_cnd(einst_t e, logic [2:0] c);
        logic zf, sf, of;
        {zf, sf, of} = c;
        if (e.ic != 4'h2 && e.ic != 4'h7) return 1'b0;
        case (e.fn)
            4'h0:    return 1'b1;
            4'h1:    return (sf ^ of) | zf;
            4'h2:    return sf ^ of;
            4'h3:    return zf;
            4'h4:    return !zf;
            4'h5:    return !(sf ^ of);
            4'h6:    return !(sf ^ of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_dstE(einst_t e, logic [2:0] c);
        if (e.ic == 4'h2 && !ref_cnd(e, c)) return 4'hF;
        return e.de;
    endfunction

    task automatic model_reset();
        me  = '{v: 1'b0, ic: 4'h1, fn: 4'h0, a: 64'd0, b: 64'd0, c: 64'd0, p: 64'd0, de: 4'hF, dm: 4'hF};
        mm  = '{v: 1'b0, ic: 4'h1, cnd: 1'b0, ve: 64'd0, a: 64'd0, p: 64'd0, de: 4'hF, dm: 4'hF};
        mcc = 3'b100;
    endtask

    task automatic model_edge();
        minst_t     nm;
        logic [2:0] nf;
        if (stall) return;
        nm  = '{v: me.v, ic: me.ic, cnd: ref_cnd(me, mcc), ve: ref_valE(me), a: me.a, p: me.p,
                de: ref_dstE(me, mcc), dm: me.dm};
        nf  = ref_flags(me);
        if (!m_bubble && !cc_hold && me.v && me.ic == 4'h6 && me.fn <= 4'h3) mcc = nf;
        if (m_bubble) begin
            mm = '{v: 1'b0, ic: 4'h1, cnd: 1'b0, ve: 64'd0, a: 64'd0, p: 64'd0, de: 4'hF, dm: 4'hF};
        end else begin
            mm = nm;
        end
        if (e_bubble) begin
            me = '{v: 1'b0, ic: 4'h1, fn: 4'h0, a: 64'd0, b: 64'd0, c: 64'd0, p: 64'd0, de: 4'hF, dm: 4'hF};
        end else begin
            me = '{v: d_valid, ic: d_icode, fn: d_ifun, a: d_valA, b: d_valB, c: d_valC, p: d_valP,
                   de: d_dstE, dm: d_dstM};
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("m_valid", 64'(m_valid), 64'(mm.v));
        check("m_icode", 64'(m_icode), 64'(mm.ic));
        check("m_cnd",   64'(m_cnd),   64'(mm.cnd));
        check("m_valE",  m_valE,       mm.ve);
        check("m_valA",  m_valA,       mm.a);
        check("m_valP",  m_valP,       mm.p);
        check("m_dstE",  64'(m_dstE),  64'(mm.de));
        check("m_dstM",  64'(m_dstM),  64'(mm.dm));
        check("cc",      64'(cc),      64'(mcc));
        check("e_valE",  e_valE,       ref_valE(me));
        check("e_dstE",  64'(e_dstE),  64'(ref_dstE(me, mcc)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [3:0] de);
        d_valid = 1'b1; d_icode = ic; d_ifun = fn;
        d_valA = a; d_valB = b; d_valC = c; d_valP = c + 64'd10;
        d_dstE = de; d_dstM = 4'hF;
    endtask

    task automatic drive_nop();
        d_valid = 1'b0; d_icode = 4'h1; d_ifun = 4'h0;
        d_valA = 64'd0; d_valB = 64'd0; d_valC = 64'd0; d_valP = 64'd0;
        d_dstE = 4'hF; d_dstM = 4'hF;
    endtask

    // Issue one instruction followed by a nop; afterwards it sits in M
    task automatic run(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de);
        drive(ic, fn, a, b, c, de);
        step();
        drive_nop();
        step();
    endtask

    function automatic logic [63:0] rval();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 16));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; e_bubble = 1'b0; m_bubble = 1'b0; cc_hold = 1'b0;
        drive_nop();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_m_icode", 64'(m_icode), 64'h1);
        check("rst_m_dstE",  64'(m_dstE),  64'hF);
        check("rst_m_valid", 64'(m_valid), 64'h0);
        check("rst_cc",      64'(cc),      64'h4);
        compare_all();
        rst_n = 1'b1;

        run(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h2);
        check("sub33_valE", m_valE, 64'd0);
        check("sub33_cc",   64'(cc), 64'h4);
        run(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2);
        check("sub10_valE", m_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub10_cc",   64'(cc), 64'h2);
        run(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2);
        check("addov_valE", m_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("addov_cc",   64'(cc), 64'h3);

        run(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h2);
        cc_hold = 1'b1;
        run(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2);
        cc_hold = 1'b0;
        check("hold_valE", m_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("hold_cc",   64'(cc), 64'h4);

        run(4'h2, 4'h1, 64'd5, 64'd0, 64'd0, 4'h3);
        check("cmovle_cnd",  64'(m_cnd),  64'h1);
        check("cmovle_dstE", 64'(m_dstE), 64'h3);
        check("cmovle_valE", m_valE, 64'd5);
        run(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
        check("add11_cc", 64'(cc), 64'h0);
        run(4'h2, 4'h2, 64'd5, 64'd0, 64'd0, 4'h3);
        check("cmovl_cnd",  64'(m_cnd),  64'h0);
        check("cmovl_dstE", 64'(m_dstE), 64'hF);
        run(4'h7, 4'h6, 64'd0, 64'd0, 64'h40, 4'hF);
        check("jg_cnd", 64'(m_cnd), 64'h1);

        run(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
        check("push_valE", m_valE, 64'hF8);
        run(4'hB, 4'h0, 64'h1234, 64'h100, 64'd0, 4'h4);
        check("pop_valE", m_valE, 64'h108);
        check("pop_valA", m_valA, 64'h1234);

        drive(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h2);
        step();
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h80, 4'hF);
        step();
        drive_nop();
        step();
        check("b2b_je_icode", 64'(m_icode), 64'h7);
        check("b2b_je_cnd",   64'(m_cnd),   64'h1);

        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h55, 4'h2);
        step();
        stall = 1'b1;
        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'hAA, 4'h2);
        step();
        step();
        check("stall_m_icode", 64'(m_icode), 64'h1);
        check("stall_m_valid", 64'(m_valid), 64'h0);
        check("stall_cc",      64'(cc),      64'h4);
        stall = 1'b0;
        drive_nop();
        step();
        check("unstall_valE",  m_valE, 64'h55);
        check("unstall_icode", 64'(m_icode), 64'h3);

        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h66, 4'h2);
        step();
        stall = 1'b1; e_bubble = 1'b1;
        drive_nop();
        step();
        stall = 1'b0; e_bubble = 1'b0;
        step();
        check("stallwins_valE",  m_valE, 64'h66);
        check("stallwins_icode", 64'(m_icode), 64'h3);

        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h77, 4'h2);
        e_bubble = 1'b1;
        step();
        e_bubble = 1'b0;
        drive_nop();
        step();
        check("ebub_icode", 64'(m_icode), 64'h1);
        check("ebub_valid", 64'(m_valid), 64'h0);
        check("ebub_valE",  m_valE, 64'd0);

        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h88, 4'h2);
        step();
        m_bubble = 1'b1;
        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h99, 4'h2);
        step();
        check("mbub_icode", 64'(m_icode), 64'h1);
        check("mbub_valid", 64'(m_valid), 64'h0);
        m_bubble = 1'b0;
        drive_nop();
        step();
        check("mbub_next_valE", m_valE, 64'h99);

        run(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
        check("prerst_icode", 64'(m_icode), 64'h6);
        stall = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_m_icode", 64'(m_icode), 64'h1);
        check("arst_m_dstE",  64'(m_dstE),  64'hF);
        check("arst_m_valid", 64'(m_valid), 64'h0);
        check("arst_cc",      64'(cc),      64'h4);
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        compare_all();

        for (int i = 0; i < 800; i++) begin
            d_valid  = ($urandom_range(0, 9) != 0);
            d_icode  = 4'($urandom_range(0, 11));
            d_ifun   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            d_valA   = rval();
            d_valB   = rval();
            d_valC   = rval();
            d_valP   = {$urandom, $urandom};
            d_dstE   = 4'($urandom_range(0, 15));
            d_dstM   = 4'($urandom_range(0, 15));
            stall    = ($urandom_range(0, 7) == 0);
            e_bubble = ($urandom_range(0, 9) == 0);
            m_bubble = ($urandom_range(0, 9) == 0);
            cc_hold  = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
